mem_stage_nested: RTL

Parametrised memory-access pipeline stage that sits between EX and WB and drives the MEM_WB pipeline register. It carries byte/halfword/word (and doubleword at 64-bit width) loads and stores with byte enables and sign/zero extension. A ready handshake lets it wait on slow memory or peripherals. A BACKUP_DEPTH-deep stack of saved MEM_WB contents supports nested interrupt backup and recovery.

---
 rtl/mem_stage_nested_if.sv | 8 +
 rtl/mem_stage_nested.sv | 94 +++++++++
 2 files changed

// File: rtl/mem_stage_nested_if.sv
// mem_stage_nested_if: memory bus between the MEM stage and memory or peripherals
interface mem_stage_nested_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] bus_addr, bus_wdata, bus_rdata;
  logic [DATA_W/8-1:0] bus_be;
  logic bus_rd, bus_wr, bus_ready;
  modport master(output bus_addr, bus_wdata, bus_be, bus_rd, bus_wr, input bus_rdata, bus_ready);
  modport slave(input bus_addr, bus_wdata, bus_be, bus_rd, bus_wr, output bus_rdata, bus_ready);
endinterface

// File: rtl/mem_stage_nested.sv
// mem_stage_nested: EX->WB memory-access stage with wait-state handshake and nested IRQ MEM_WB backup stack
module mem_stage_nested #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int BACKUP_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic [DATA_W-1:0] alu_s,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic mem_read,
  input  logic mem_write,
  input  logic [1:0] mem_size,
  input  logic mem_signed,
  input  logic [REG_AW-1:0] write_reg,
  input  logic reg_write,
  input  logic [1:0] mem_to_reg,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic lu_op,
  input  logic [DATA_W-1:0] lu_data,
  input  logic irq_backup,
  input  logic irq_recovery,
  mem_stage_nested_if.master bus,
  output logic stall,
  output logic [DATA_W-1:0] mem_wb_data,
  output logic [REG_AW-1:0] mem_wb_reg,
  output logic mem_wb_we,
  output logic misalign,
  output logic [$clog2(BACKUP_DEPTH):0] backup_level,
  output logic backup_err
);
  localparam int LANE_W = $clog2(DATA_W/8);
  localparam int LW = $clog2(BACKUP_DEPTH) + 1;
  localparam int IW = BACKUP_DEPTH > 1 ? $clog2(BACKUP_DEPTH) : 1;
  localparam int WB_W = DATA_W + REG_AW + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0] state;
  logic req, mis, valid, irq_any, go;
  logic [2:0] am;
  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] sh, lmask, top, ld, wb;
  logic [DATA_W/8-1:0] be_base;
  logic [WB_W-1:0] mem_wb;
  logic [WB_W-1:0] stack [BACKUP_DEPTH];
  assign {mem_wb_data, mem_wb_reg, mem_wb_we} = mem_wb;
  always_comb begin
    req = mem_read | mem_write;
    am = mem_size == 2'd0 ? 3'd0 : mem_size == 2'd1 ? 3'd1 : mem_size == 2'd2 ? 3'd3 : 3'd7;
    mis = req & ((|(alu_s[2:0] & am)) | (mem_size == 2'd3 && DATA_W == 32));
    valid = req & ~mis;
    irq_any = irq_backup | irq_recovery;
    go = valid & reset_b & ~irq_any;
    lane = alu_s[LANE_W-1:0];
    bus.bus_addr = {alu_s[DATA_W-1:LANE_W], LANE_W'(0)};
    bus.bus_wdata = mem_size == 2'd0 ? {(DATA_W/8){mem_write_data[7:0]}} :
                    mem_size == 2'd1 ? {(DATA_W/16){mem_write_data[15:0]}} :
                    mem_size == 2'd2 ? {(DATA_W/32){mem_write_data[31:0]}} : mem_write_data;
    be_base = ~({(DATA_W/8){1'b1}} << (1 << mem_size));
    bus.bus_be = go ? be_base << lane : '0;
    bus.bus_rd = go & mem_read;
    bus.bus_wr = go & mem_write;
    stall = reset_b & ~bus.bus_ready & (state | valid);
    sh = bus.bus_rdata >> {lane, 3'b000};
    lmask = ~({DATA_W{1'b1}} << (8 << mem_size));
    top = lmask & ~(lmask >> 1);
    ld = (sh & lmask) | (mem_signed && |(sh & top) ? ~lmask : '0);
    wb = lu_op ? lu_data : mem_to_reg[1] ? pc_plus4 : mem_to_reg[0] ? ld : alu_s;
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= IDLE;
      mem_wb <= '0;
      misalign <= 1'b0;
      backup_level <= '0;
      backup_err <= 1'b0;
    end else begin
      state <= stall && !irq_any ? WAIT : IDLE;
      misalign <= mis;
      if (irq_recovery) begin
        mem_wb <= backup_level != '0 ? stack[IW'(backup_level - 1'b1)] : '0;
        backup_level <= backup_level != '0 ? backup_level - 1'b1 : backup_level;
        backup_err <= backup_err | (backup_level == '0);
      end else if (irq_backup) begin
        mem_wb <= '0;
        backup_level <= backup_level != LW'(BACKUP_DEPTH) ? backup_level + 1'b1 : backup_level;
        backup_err <= backup_err | (backup_level == LW'(BACKUP_DEPTH));
      end else
        mem_wb <= stall ? '0 : {wb, write_reg, reg_write & ~mis};
    end
  always_ff @(posedge clk)
    if (irq_backup && !irq_recovery && backup_level != LW'(BACKUP_DEPTH))
      stack[IW'(backup_level)] <= mem_wb;
endmodule
